// File: rtl/sequence_ctrl_pkg.sv
// Shared types and power-on table contents for the a/b/c step sequencer.
package sequence_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  typedef logic [2:0] pattern_t;

  localparam pattern_t RST_PAT0    = 3'b100;
  localparam pattern_t RST_PAT1    = 3'b010;
  localparam pattern_t RST_PAT2    = 3'b001;
  localparam int       RST_END_IDX = 2;

  // Entries beyond the classic three-phase rotation come up blank.
  function automatic pattern_t rstPattern(input int idx);
    case (idx)
      0:       return RST_PAT0;
      1:       return RST_PAT1;
      2:       return RST_PAT2;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/sequence_step_table.sv
// Step table register file: pattern, dwell and end flag per entry, with a
// gated write port, combinational read and first-end-flag detection.
module sequence_step_table
  import sequence_ctrl_pkg::*;
#(
  parameter int NUM_STEPS = 4,
  parameter int DWELL_W   = 8,
  parameter int IDX_W     = $clog2(NUM_STEPS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we_i,
  input  logic [IDX_W-1:0]   wrAddr_i,
  input  logic [2:0]         wrPattern_i,
  input  logic [DWELL_W-1:0] wrDwell_i,
  input  logic               wrEnd_i,
  input  logic [IDX_W-1:0]   rdAddr_i,
  output logic [2:0]         rdPattern_o,
  output logic [DWELL_W-1:0] rdDwell_o,
  output logic [IDX_W-1:0]   endIdx_o
);

  pattern_t           patterns_q [NUM_STEPS];
  logic [DWELL_W-1:0] dwells_q   [NUM_STEPS];
  logic               ends_q     [NUM_STEPS];

  logic               addrValid;

  assign addrValid = (32'(wrAddr_i) < NUM_STEPS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STEPS; i++) begin
        patterns_q[i] <= rstPattern(i);
        dwells_q[i]   <= '0;
        ends_q[i]     <= (i == RST_END_IDX);
      end
    end else if (we_i && addrValid) begin
      patterns_q[wrAddr_i] <= wrPattern_i;
      dwells_q[wrAddr_i]   <= wrDwell_i;
      ends_q[wrAddr_i]     <= wrEnd_i;
    end
  end

  assign rdPattern_o = patterns_q[rdAddr_i];
  assign rdDwell_o   = dwells_q[rdAddr_i];

  // Scan downwards so the lowest flagged entry wins; the last entry is the
  // fallback end when nothing is flagged.
  always_comb begin
    endIdx_o = IDX_W'(NUM_STEPS - 1);
    for (int i = NUM_STEPS - 1; i >= 0; i--) begin
      if (ends_q[i]) endIdx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/sequence_ctrl.sv
// Programmable a/b/c step sequencer: start/stop handshake, one-shot or
// looping walk of the step table, registered pattern and progress outputs.
module sequence_ctrl
  import sequence_ctrl_pkg::*;
#(
  parameter int NUM_STEPS = 4,
  parameter int DWELL_W   = 8,
  parameter int IDX_W     = $clog2(NUM_STEPS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               loop,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_addr,
  input  logic [2:0]         cfg_pattern,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_end,
  output logic               a,
  output logic               b,
  output logic               c,
  output logic               busy,
  output logic               done,
  output logic [IDX_W-1:0]   step
);

  state_t             state_q;
  pattern_t           pattern_q;
  logic               busy_q;
  logic               done_q;
  logic               loop_q;
  logic [IDX_W-1:0]   step_q;
  logic [IDX_W-1:0]   step_d;
  logic [DWELL_W-1:0] dwell_q;

  logic               tblWe;
  logic [2:0]         rdPattern;
  logic [DWELL_W-1:0] rdDwell;
  logic [IDX_W-1:0]   endIdx;

  assign tblWe = cfg_we && (state_q != ST_RUN);

  sequence_step_table #(
    .NUM_STEPS (NUM_STEPS),
    .DWELL_W   (DWELL_W),
    .IDX_W     (IDX_W)
  ) u_table (
    .clk         (clk),
    .rst_n       (rst_n),
    .we_i        (tblWe),
    .wrAddr_i    (cfg_addr),
    .wrPattern_i (cfg_pattern),
    .wrDwell_i   (cfg_dwell),
    .wrEnd_i     (cfg_end),
    .rdAddr_i    (step_d),
    .rdPattern_o (rdPattern),
    .rdDwell_o   (rdDwell),
    .endIdx_o    (endIdx)
  );

  // The table is always read at the step that would be entered next, so a
  // launch, advance or wrap can load pattern and dwell in the same edge.
  always_comb begin
    step_d = '0;
    if (state_q == ST_RUN && step_q != endIdx) step_d = step_q + IDX_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pattern_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      loop_q    <= 1'b0;
      step_q    <= '0;
      dwell_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start && !stop) begin
            state_q   <= ST_RUN;
            loop_q    <= loop;
            step_q    <= step_d;
            pattern_q <= rdPattern;
            dwell_q   <= rdDwell;
            busy_q    <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_q   <= ST_IDLE;
            pattern_q <= '0;
            busy_q    <= 1'b0;
            step_q    <= '0;
          end else if (dwell_q != '0) begin
            dwell_q <= dwell_q - DWELL_W'(1);
          end else if (step_q == endIdx && !loop_q) begin
            state_q   <= ST_DONE;
            pattern_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            step_q    <= '0;
          end else begin
            step_q    <= step_d;
            pattern_q <= rdPattern;
            dwell_q   <= rdDwell;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign {a, b, c} = pattern_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign step      = step_q;

endmodule
